// File: rtl/sampler_pkg.sv
// Shared types and constants for the sampler voice scheduler.
// Scheduler/voice state encodings, sample width and saturation bounds.
// Pure declarations; no logic.
package sampler_pkg;

  localparam int DATA_W  = 24;
  localparam int SAT_MAX = (1 << (DATA_W - 1)) - 1;
  localparam int SAT_MIN = -(1 << (DATA_W - 1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_COMMIT
  } sched_state_e;

  typedef enum logic {
    V_IDLE,
    V_PLAY
  } voice_state_e;

endpackage

// File: rtl/sampler_voice_fsm.sv
// Per-voice playback state: key edge detect, pending start, IDLE/PLAY state, read position.
// Latency: key rise -> pending next cycle; start applied while scheduler idle or at commit.
// No backpressure: a start waits in pending until the scheduler reaches idle or commit.
module sampler_voice_fsm
  import sampler_pkg::*;
#(
  parameter int REGION_W   = 15,
  parameter int SAMPLE_LEN = 32768
) (
  input  logic                clk,
  input  logic                rst_n_i,
  input  logic                trig_i,
  input  logic                loop_en_i,
  input  logic                sched_idle_i,
  input  logic                commit_i,
  input  logic                snap_active_i,
  output logic                active_o,
  output logic [REGION_W-1:0] pos_o
);

  localparam logic [REGION_W-1:0] LAST_POS = REGION_W'(SAMPLE_LEN - 1);

  voice_state_e        state_q, state_d;
  logic [REGION_W-1:0] pos_q, pos_d;
  logic                trig_q;
  logic                pending_q, pending_d;
  logic                start;

  // Next state: a pending start beats the commit-time advance of this voice.
  always_comb begin
    start     = pending_q & (sched_idle_i | commit_i);
    pending_d = (pending_q & ~start) | (trig_i & ~trig_q);
    state_d   = state_q;
    pos_d     = pos_q;
    if (start) begin
      state_d = V_PLAY;
      pos_d   = '0;
    end else if (commit_i && snap_active_i) begin
      if (pos_q != LAST_POS) begin
        pos_d = pos_q + REGION_W'(1);
      end else if (loop_en_i && trig_q) begin
        pos_d = '0;
      end else begin
        state_d = V_IDLE;
        pos_d   = '0;
      end
    end
  end

  // Voice registers, including the key history used for edge detection.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= V_IDLE;
      pos_q     <= '0;
      trig_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      trig_q    <= trig_i;
      pending_q <= pending_d;
    end
  end

  assign active_o = (state_q == V_PLAY);
  assign pos_o    = pos_q;

endmodule

// File: rtl/sampler_voice_scheduler.sv
// Time-multiplexes the shared sample RAM over all voices per tick and mixes with saturation.
// Latency: tick -> sample_valid = NUM_VOICES + RD_LAT + 1 cycles.
// No backpressure: ticks arriving while a sequence runs are dropped and flag overrun.
module sampler_voice_scheduler
  import sampler_pkg::*;
#(
  parameter int NUM_VOICES = 2,
  parameter int REGION_W   = 15,
  parameter int SAMPLE_LEN = 32768,
  parameter int RD_LAT     = 2,
  localparam int VIDX_W    = $clog2(NUM_VOICES),
  localparam int ADDR_W    = VIDX_W + REGION_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic [NUM_VOICES-1:0]    trig,
  input  logic                     loop_en,
  output logic [ADDR_W-1:0]        ram_addr,
  input  logic signed [DATA_W-1:0] ram_q_l,
  input  logic signed [DATA_W-1:0] ram_q_r,
  output logic signed [DATA_W-1:0] left_out,
  output logic signed [DATA_W-1:0] right_out,
  output logic                     sample_valid,
  output logic [NUM_VOICES-1:0]    voice_active,
  output logic                     overrun
);

  localparam int ACC_W = DATA_W + VIDX_W + 1;
  localparam int CNT_W = $clog2(NUM_VOICES + RD_LAT) + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(SAT_MIN);

  function automatic logic [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
    if (a > ACC_MAX)      return DATA_W'(SAT_MAX);
    else if (a < ACC_MIN) return DATA_W'(SAT_MIN);
    else                  return a[DATA_W-1:0];
  endfunction

  sched_state_e              state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      issue, seq_start, load_out;
  logic [NUM_VOICES-1:0]     active, snap_q;
  logic [REGION_W-1:0]       pos [NUM_VOICES];
  logic [VIDX_W-1:0]         issue_idx;
  logic [RD_LAT-1:0]         vld_pipe_q;
  logic [VIDX_W-1:0]         idx_pipe_q [RD_LAT];
  logic                      tap_vld;
  logic signed [ACC_W-1:0]   acc_l_q, acc_r_q, acc_l_d, acc_r_d;
  logic [DATA_W-1:0]         left_q, right_q;
  logic                      sample_valid_q, overrun_q;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    sampler_voice_fsm #(
      .REGION_W   (REGION_W),
      .SAMPLE_LEN (SAMPLE_LEN)
    ) u_voice (
      .clk           (clk),
      .rst_n_i       (reset),
      .trig_i        (trig[v]),
      .loop_en_i     (loop_en),
      .sched_idle_i  (state_q == S_IDLE),
      .commit_i      (state_q == S_COMMIT),
      .snap_active_i (snap_q[v]),
      .active_o      (active[v]),
      .pos_o         (pos[v])
    );
  end

  // Sequencer next state: one issue cycle per voice, RD_LAT drain cycles, one commit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    issue     = 1'b0;
    seq_start = 1'b0;
    load_out  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d   = S_ISSUE;
          cnt_d     = '0;
          seq_start = 1'b1;
        end
      end
      S_ISSUE: begin
        issue = 1'b1;
        if (cnt_q == CNT_W'(NUM_VOICES - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        // Last read lands this cycle; outputs load so they are visible during commit.
        if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          state_d  = S_COMMIT;
          load_out = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Read address and accumulate: inactive voices are still addressed but contribute zero.
  always_comb begin
    issue_idx = cnt_q[VIDX_W-1:0];
    ram_addr  = issue ? {issue_idx, pos[issue_idx]} : '0;
    tap_vld   = vld_pipe_q[RD_LAT-1] & snap_q[idx_pipe_q[RD_LAT-1]];
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    if (tap_vld) begin
      acc_l_d = acc_l_q + {{(ACC_W-DATA_W){ram_q_l[DATA_W-1]}}, ram_q_l};
      acc_r_d = acc_r_q + {{(ACC_W-DATA_W){ram_q_r[DATA_W-1]}}, ram_q_r};
    end
  end

  // Sequencer state, active snapshot, and sticky overrun flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      snap_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (seq_start) snap_q <= active;
      if (tick && (state_q != S_IDLE)) overrun_q <= 1'b1;
    end
  end

  // Read-return tracking, accumulators and registered mixed outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe_q     <= '0;
      for (int i = 0; i < RD_LAT; i++) idx_pipe_q[i] <= '0;
      acc_l_q        <= '0;
      acc_r_q        <= '0;
      left_q         <= '0;
      right_q        <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      vld_pipe_q[0] <= issue;
      idx_pipe_q[0] <= issue_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        idx_pipe_q[i] <= idx_pipe_q[i-1];
      end
      if (seq_start) begin
        acc_l_q <= '0;
        acc_r_q <= '0;
      end else begin
        acc_l_q <= acc_l_d;
        acc_r_q <= acc_r_d;
      end
      if (load_out) begin
        left_q  <= saturate(acc_l_d);
        right_q <= saturate(acc_r_d);
      end
      sample_valid_q <= load_out;
    end
  end

  assign left_out     = left_q;
  assign right_out    = right_q;
  assign sample_valid = sample_valid_q;
  assign voice_active = active;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_sampler_voice_scheduler.sv
// Directed bench for sampler_voice_scheduler: default instance plus a SAMPLE_LEN=4 instance.
// RAM models return q_l = address, q_r = -address after two clk cycles.
// All waits are bounded by cycle counts.
module tb_sampler_voice_scheduler;

  logic        clk = 1'b0;
  logic        reset, tick, loop_en, tick4, loop4;
  logic [1:0]  trig, trig4;
  logic [15:0] ram_addr, addr4;
  logic [23:0] q_l, q_r, q4_l, q4_r;
  logic [23:0] left_out, right_out, left4, right4;
  logic        sample_valid, sv4, overrun, ovr4;
  logic [1:0]  voice_active, va4;
  logic [15:0] a_q, a4_q;
  logic        force_en;
  logic [23:0] force_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sampler_voice_scheduler u_dut (
    .clk(clk), .reset(reset), .tick(tick), .trig(trig), .loop_en(loop_en),
    .ram_addr(ram_addr), .ram_q_l(q_l), .ram_q_r(q_r),
    .left_out(left_out), .right_out(right_out), .sample_valid(sample_valid),
    .voice_active(voice_active), .overrun(overrun)
  );

  sampler_voice_scheduler #(.SAMPLE_LEN(4)) u_dut4 (
    .clk(clk), .reset(reset), .tick(tick4), .trig(trig4), .loop_en(loop4),
    .ram_addr(addr4), .ram_q_l(q4_l), .ram_q_r(q4_r),
    .left_out(left4), .right_out(right4), .sample_valid(sv4),
    .voice_active(va4), .overrun(ovr4)
  );

  // Two-cycle RAM: registered address, then registered data.
  always @(posedge clk) begin
    a_q  <= ram_addr;
    a4_q <= addr4;
    if (force_en) begin
      q_l <= force_val;
      q_r <= force_val;
    end else begin
      q_l <= {8'h00, a_q};
      q_r <= 24'd0 - {8'h00, a_q};
    end
    q4_l <= {8'h00, a4_q};
    q4_r <= 24'd0 - {8'h00, a4_q};
  end

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse tick on one instance, measure latency to sample_valid, confirm it is one cycle wide.
  task automatic run_tick(input bit sel);
    int lat;
    bit seen;
    if (sel) tick4 = 1'b1; else tick = 1'b1;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      tick  = 1'b0;
      tick4 = 1'b0;
      lat++;
      seen = sel ? sv4 : sample_valid;
    end
    check(sel ? "latency4" : "latency", 24'(lat), 24'd5);
    @(negedge clk);
    check(sel ? "pulse_width4" : "pulse_width", 24'(sel ? sv4 : sample_valid), 24'd0);
  endtask

  initial begin
    int lat, pulses;
    logic [23:0] cap_l, cap_r;
    reset = 1'b0; tick = 1'b0; tick4 = 1'b0; trig = 2'b00; trig4 = 2'b00;
    loop_en = 1'b0; loop4 = 1'b0; force_en = 1'b0; force_val = 24'd0;
    step(3);
    check("rst_left", left_out, 24'd0);
    check("rst_right", right_out, 24'd0);
    check("rst_valid", 24'(sample_valid), 24'd0);
    check("rst_active", 24'(voice_active), 24'd0);
    check("rst_overrun", 24'(overrun), 24'd0);
    check("rst_addr", 24'(ram_addr), 24'd0);
    reset = 1'b1;
    step(2);

    // Voice 0 one-shot from pos 0.
    trig = 2'b01;
    step(3);
    check("v0_active", 24'(voice_active), 24'd1);
    for (int k = 0; k < 3; k++) begin
      run_tick(1'b0);
      check("v0_left", left_out, 24'(k));
      check("v0_right", right_out, 24'(-k));
    end
    check("v0_active_after", 24'(voice_active), 24'd1);

    // Release does not stop a one-shot voice.
    trig = 2'b00;
    for (int k = 3; k < 7; k++) begin
      run_tick(1'b0);
      check("released_left", left_out, 24'(k));
    end
    check("released_active", 24'(voice_active), 24'd1);

    // Retrigger voice 0 (at pos 7) while the scheduler is issuing.
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    trig = 2'b01;
    lat = 1;
    while (!sample_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("retrig_latency", 24'(lat), 24'd5);
    check("retrig_old_pos", left_out, 24'd7);
    @(negedge clk);
    run_tick(1'b0);
    check("retrig_pos0", left_out, 24'd0);
    for (int k = 1; k < 5; k++) begin
      run_tick(1'b0);
      check("retrig_follow", left_out, 24'(k));
    end

    // Voice 1 joins while voice 0 is at pos 5.
    trig = 2'b11;
    step(3);
    check("both_active", 24'(voice_active), 24'd3);
    for (int i = 0; i < 5; i++) begin
      run_tick(1'b0);
      check("mix_left", left_out, 24'(5 + i + 32768 + i));
    end
    run_tick(1'b0);
    check("mix_10_5_left", left_out, 24'd32783);
    check("mix_10_5_right", right_out, 24'(-32783));
    check("no_overrun_yet", 24'(overrun), 24'd0);

    // Second tick two cycles into a sequence is dropped and flags overrun.
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("issue_addr_v0", 24'(ram_addr), 24'd11);
    @(negedge clk);
    check("issue_addr_v1", 24'(ram_addr), 24'(32768 + 6));
    tick = 1'b1;
    pulses = 0;
    cap_l = 24'd0;
    cap_r = 24'd0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      tick = 1'b0;
      if (sample_valid) begin
        pulses++;
        cap_l = left_out;
        cap_r = right_out;
      end
    end
    check("overrun_pulses", 24'(pulses), 24'd1);
    check("overrun_left", cap_l, 24'd32785);
    check("overrun_right", cap_r, 24'(-32785));
    check("overrun_flag", 24'(overrun), 24'd1);

    // Saturation at both rails.
    force_en = 1'b1;
    force_val = 24'h7FFFFF;
    run_tick(1'b0);
    check("sat_pos_left", left_out, 24'h7FFFFF);
    check("sat_pos_right", right_out, 24'h7FFFFF);
    force_val = 24'h800000;
    run_tick(1'b0);
    check("sat_neg_left", left_out, 24'h800000);
    check("sat_neg_right", right_out, 24'h800000);
    force_en = 1'b0;
    run_tick(1'b0);
    check("post_sat_left", left_out, 24'd32791);
    check("overrun_sticky", 24'(overrun), 24'd1);

    // Reset two cycles into a sequence.
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_left", left_out, 24'd0);
    check("midrst_right", right_out, 24'd0);
    check("midrst_valid", 24'(sample_valid), 24'd0);
    check("midrst_active", 24'(voice_active), 24'd0);
    check("midrst_overrun", 24'(overrun), 24'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 1) reset = 1'b1;
      if (sample_valid) pulses++;
    end
    check("midrst_no_valid", 24'(pulses), 24'd0);
    check("midrst_restart", 24'(voice_active), 24'd3);
    run_tick(1'b0);
    check("midrst_next_left", left_out, 24'd32768);
    check("midrst_next_right", right_out, 24'(-32768));

    // SAMPLE_LEN=4 instance: one-shot ends after pos 3 when released.
    trig4 = 2'b01;
    step(3);
    check("l4_active", 24'(va4), 24'd1);
    run_tick(1'b1);
    check("l4_left", left4, 24'd0);
    trig4 = 2'b00;
    for (int k = 1; k < 4; k++) begin
      run_tick(1'b1);
      check("l4_left", left4, 24'(k));
    end
    check("l4_right", right4, 24'(-3));
    check("l4_idle_after_end", 24'(va4), 24'd0);
    run_tick(1'b1);
    check("l4_idle_masked", left4, 24'd0);

    // Held key with looping wraps back to pos 0.
    trig4 = 2'b01;
    loop4 = 1'b1;
    step(3);
    for (int k = 0; k < 4; k++) begin
      run_tick(1'b1);
      check("loop_left", left4, 24'(k));
    end
    run_tick(1'b1);
    check("loop_wrap_left", left4, 24'd0);
    check("loop_still_active", 24'(va4), 24'd1);
    run_tick(1'b1);
    check("loop_next_left", left4, 24'd1);
    check("l4_no_overrun", 24'(ovr4), 24'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
